// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS pipeline control blocks.
//   fwd_sel_t   : E-stage operand source select
//   mem_state_t : data-memory wait sequencer state
//   REG_ZERO    : $zero, never a forwarding/hazard source
package mips_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // E-stage operand select; the younger M result wins over W.
  function automatic fwd_sel_t fwd_e_sel(
    input logic [4:0] src,
    input logic [4:0] wreg_m, input logic wen_m,
    input logic [4:0] wreg_w, input logic wen_w
  );
    if (src != REG_ZERO && wen_m && src == wreg_m)      return FWD_MEM;
    else if (src != REG_ZERO && wen_w && src == wreg_w) return FWD_WB;
    else                                                return FWD_RF;
  endfunction

  // True when a destination register (with its valid qualifier) matches either D source.
  function automatic logic dst_hits_d(
    input logic       qual,
    input logic [4:0] dst,
    input logic [4:0] rs, input logic [4:0] rt
  );
    return qual && dst != REG_ZERO && (dst == rs || dst == rt);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy tracker.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : accepted mult/div issue (already qualified by !StallE)
//   busy       : unit occupied; high for exactly MD_LATENCY cycles after start
// A start while busy reloads the countdown.
module md_busy_counter #(
  parameter int MD_LATENCY = 32,
  parameter int MD_CW      = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam logic [MD_CW-1:0] LOAD = MD_CW'(MD_LATENCY - 1);

  logic [MD_CW-1:0] cnt;

  // busy rises with the load and falls on the edge after cnt has sat at 0,
  // giving LOAD+1 = MD_LATENCY busy cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= LOAD;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall controller for the 5-stage MIPS pipeline.
//   clk, rst_n                     : clock, synchronous active-low reset
//   RsD/RtD, RsE/RtE               : source regs in D / E
//   WriteRegE/M/W, RegWriteE/M/W   : destination reg and write enable per stage
//   MemtoRegE/M                    : load in E / M
//   BranchD, MDStartE, MDUseD      : branch in D, mult/div issue in E, HI/LO user in D
//   MemReqM, MemReadyM             : data-memory request / done pulse
//   StallF/D/E/M, FlushE           : pipeline register hold / ID-EX bubble
//   ForwardAD/BD, ForwardAE/BE     : operand forwarding selects
//   MDBusy                         : mult/div unit occupied
//   StallCycles, LoadUseCnt        : perf counters, present only with HAZ_PERF_CNT_EN
module hazard_ctrl_unit
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int MD_CW      = 6
`ifdef HAZ_PERF_CNT_EN
 ,parameter int PERF_W     = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MDStartE,
  input  logic       MDUseD,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MDBusy
`ifdef HAZ_PERF_CNT_EN
 ,output logic [PERF_W-1:0] StallCycles,
  output logic [PERF_W-1:0] LoadUseCnt
`endif
);

  // Forwarding
  assign ForwardAE = fwd_e_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  assign ForwardBE = fwd_e_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
  assign ForwardAD = (RsD != REG_ZERO) && RegWriteM && (RsD == WriteRegM);
  assign ForwardBD = (RtD != REG_ZERO) && RegWriteM && (RtD == WriteRegM);

  // Hazard detection
  logic lwstall, brstall, mdstall, memstall;

  assign lwstall = dst_hits_d(MemtoRegE, WriteRegE, RsD, RtD);
  // A branch compares in D, so an ALU result still in E or a load still in M
  // cannot be forwarded in time.
  assign brstall = BranchD && (dst_hits_d(RegWriteE, WriteRegE, RsD, RtD) ||
                               dst_hits_d(MemtoRegM, WriteRegM, RsD, RtD));
  assign mdstall = MDUseD && MDBusy;

  // Data-memory wait sequencer
  mem_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    memstall  = 1'b0;
    case (state)
      RUN: if (MemReqM && !MemReadyM) begin
        memstall  = 1'b1;
        state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        // A new request cannot be raised while one is outstanding.
        memstall = !MemReadyM;
        if (MemReadyM) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Stall/flush priority: a memory wait freezes F..M and suppresses the
  // bubble so the instruction in E is held rather than squashed.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (lwstall || brstall || mdstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Mult/div occupancy; a start held in a frozen E stage is not yet issued.
  md_busy_counter #(
    .MD_LATENCY (MD_LATENCY),
    .MD_CW      (MD_CW)
  ) u_md_busy (
    .clk   (clk),
    .rst_n (rst_n),
    .start (MDStartE && !StallE),
    .busy  (MDBusy)
  );

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCycles <= '0;
      LoadUseCnt  <= '0;
    end else begin
      if (StallF)                 StallCycles <= StallCycles + 1'b1;
      if (lwstall && !memstall)   LoadUseCnt  <= LoadUseCnt + 1'b1;
    end
  end
`endif

endmodule
